path_delay_meter: RTL and testbench

PATH_DELAY_METER -- requirements
Module: path_delay_meter

---
 rtl/path_meter_pkg.sv | 23 ++
 rtl/bit_sync.sv | 44 ++++
 rtl/path_delay_meter.sv | 221 ++++++++++++++++++++++
 tb/tb_path_delay_meter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/path_meter_pkg.sv
// -----------------------------------------------------------------------------
// path_meter_pkg
// Shared definitions for the path delay meter: the controller state encoding
// and the default values of the top-level parameters.
// -----------------------------------------------------------------------------
package path_meter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT,
      SETTLE,
      DONE
   } meterState_t;

   localparam int DEF_CNT_W       = 16;    // per-trial delay counter width
   localparam int DEF_SUM_W       = 24;    // accumulated delay width
   localparam int DEF_TIMEOUT     = 1000;  // max WAIT cycles per trial
   localparam int DEF_SETTLE_CYC  = 8;     // idle cycles between trials
   localparam int DEF_INVERT      = 1;     // 1 = path has an odd inverter count
   localparam int DEF_SYNC_STAGES = 2;     // synchronizer depth on path_result

endpackage

// File: rtl/bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// STAGES-deep flop chain that brings an asynchronous bit into the clk domain.
// A synchronous load fills every stage with one level at once, so a new
// measurement starts from a known history instead of whatever the previous
// trial left behind.
//
// Ports
//   clk     : clock
//   rst     : synchronous active-high reset, clears the chain to 0
//   load    : fill every stage with loadVal this cycle
//   loadVal : level used by load
//   d       : asynchronous input
//   q       : synchronized output (last stage)
// -----------------------------------------------------------------------------
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic loadVal,
   input  logic d,
   output logic q
);

   (* keep = "true", ASYNC_REG = "TRUE" *) logic [STAGES-1:0] syncReg;

   // NOTE: flops are written with <= so every stage samples its neighbour's
   // pre-edge value; blocking writes would collapse the chain into one flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         syncReg <= '0;
      end else if (load) begin
         syncReg <= {STAGES{loadVal}};
      end else begin
         // Shift d in at stage 0; the cast drops the oldest bit.
         syncReg <= STAGES'({syncReg, d});
      end
   end

   assign q = syncReg[STAGES-1];

endmodule

// File: rtl/path_delay_meter.sv
// -----------------------------------------------------------------------------
// path_delay_meter
// Measures the propagation delay of an external asynchronous path in clk
// cycles. Each trial toggles path_launch and counts WAIT cycles until the
// synchronized path_result shows the expected new level. Successful trial
// counts are accumulated (saturating); a trial that reaches TIMEOUT aborts the
// run with a sticky timeout_err.
//
// Ports
//   clk         : clock
//   rst         : synchronous active-high reset (wins over start)
//   start       : run request, honoured only in IDLE
//   trials      : number of trials, latched on an accepted start
//   path_launch : registered drive into the delay path, keeps its level
//   path_result : asynchronous delay path output
//   busy        : high in every state except IDLE
//   done        : one-cycle completion pulse
//   timeout_err : sticky abort flag for the current run
//   delay_last  : count of the most recent successful trial
//   delay_sum   : saturating sum of successful trial counts
//   trials_done : number of successful trials
// -----------------------------------------------------------------------------
import path_meter_pkg::*;

module path_delay_meter #(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SUM_W       = DEF_SUM_W,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
   parameter int INVERT      = DEF_INVERT,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       trials,
   output logic             path_launch,
   input  logic             path_result,
   output logic             busy,
   output logic             done,
   output logic             timeout_err,
   output logic [CNT_W-1:0] delay_last,
   output logic [SUM_W-1:0] delay_sum,
   output logic [7:0]       trials_done
);

   // Parameter sanity: the counter must never wrap in WAIT or SETTLE.
   generate
      if (TIMEOUT < 1 || (TIMEOUT >> CNT_W) != 0) begin : gBadTimeout
         $error("TIMEOUT must lie in 1 .. 2**CNT_W-1");
      end
      if (SETTLE_CYC < 1 || (SETTLE_CYC >> CNT_W) != 0) begin : gBadSettle
         $error("SETTLE_CYC must lie in 1 .. 2**CNT_W-1");
      end
      if (SUM_W < CNT_W) begin : gBadSum
         $error("SUM_W must be at least CNT_W");
      end
      if (SYNC_STAGES < 1) begin : gBadSync
         $error("SYNC_STAGES must be at least 1");
      end
   endgenerate

   localparam logic             INV_BIT     = (INVERT != 0);
   localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

   meterState_t      state;
   meterState_t      stateNext;
   logic [CNT_W-1:0] cnt;          // WAIT cycles elapsed, or SETTLE cycles elapsed
   logic [CNT_W-1:0] countNow;     // cycle count including the current cycle
   logic [7:0]       trialsLat;
   logic             expected;     // level path_result must reach this trial
   logic             newExpected;  // level the next launch will expect
   logic             syncOut;
   logic             enterLaunch;
   logic             acceptRun;
   logic             acceptEmpty;
   logic             matchHit;
   logic             timeoutHit;
   logic             lastTrial;
   logic [SUM_W:0]   sumWide;
   logic [SUM_W-1:0] sumSat;

   assign countNow    = cnt + CNT_W'(1);
   assign newExpected = ~path_launch ^ INV_BIT;
   assign lastTrial   = (trials_done + 8'd1) == trialsLat;
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);

   // One extra bit catches the carry; a carry means the sum pins at all-ones.
   assign sumWide = {1'b0, delay_sum} + {{(SUM_W + 1 - CNT_W){1'b0}}, countNow};
   assign sumSat  = sumWide[SUM_W] ? '1 : sumWide[SUM_W-1:0];

   // The chain is preloaded with the level the path held before this launch
   // (the inverse of the new expected level). A plain clear to 0 would match
   // instantly whenever the expected level is 0.
   bit_sync #(
      .STAGES (SYNC_STAGES)
   ) uSync (
      .clk     (clk),
      .rst     (rst),
      .load    (enterLaunch),
      .loadVal (~newExpected),
      .d       (path_result),
      .q       (syncOut)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // path_launch toggles on the edge that enters LAUNCH, so the path is
   // already moving during the LAUNCH cycle. With a zero-delay path the first
   // stage captures it entering WAIT and the match shows on WAIT cycle
   // SYNC_STAGES, giving delay_last == SYNC_STAGES.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case
      // leaves one unassigned, which would infer a latch.
      stateNext   = state;
      enterLaunch = 1'b0;
      acceptRun   = 1'b0;
      acceptEmpty = 1'b0;
      matchHit    = 1'b0;
      timeoutHit  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (trials != 8'd0) begin
                  acceptRun   = 1'b1;
                  enterLaunch = 1'b1;
                  stateNext   = LAUNCH;
               end else begin
                  acceptEmpty = 1'b1;
                  stateNext   = DONE;
               end
            end
         end
         LAUNCH: begin
            stateNext = WAIT;
         end
         WAIT: begin
            // Match is tested first so it wins over a coincident timeout.
            if (syncOut == expected) begin
               matchHit  = 1'b1;
               stateNext = lastTrial ? DONE : SETTLE;
            end else if (countNow == TIMEOUT_C) begin
               timeoutHit = 1'b1;
               stateNext  = DONE;
            end
         end
         SETTLE: begin
            if (cnt == SETTLE_LAST) begin
               enterLaunch = 1'b1;
               stateNext   = LAUNCH;
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Shared counter: cleared at each launch and on leaving WAIT, so it counts
   // WAIT cycles during a trial and SETTLE cycles between trials.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (enterLaunch || matchHit || timeoutHit) begin
         cnt <= '0;
      end else if (state == WAIT || state == SETTLE) begin
         cnt <= countNow;
      end
   end

   // Control inputs are one-hot by state, so these updates never collide.
   always_ff @(posedge clk) begin
      if (rst) begin
         path_launch <= 1'b0;
         expected    <= 1'b0;
         trialsLat   <= '0;
         timeout_err <= 1'b0;
         delay_last  <= '0;
         delay_sum   <= '0;
         trials_done <= '0;
      end else begin
         if (enterLaunch) begin
            path_launch <= ~path_launch;
            expected    <= newExpected;
         end
         if (acceptRun) begin
            trialsLat   <= trials;
            timeout_err <= 1'b0;
            delay_sum   <= '0;
            trials_done <= '0;
         end
         if (acceptEmpty) begin
            trialsLat   <= '0;
            timeout_err <= 1'b0;
            delay_last  <= '0;
            delay_sum   <= '0;
            trials_done <= '0;
         end
         if (matchHit) begin
            delay_last  <= countNow;
            delay_sum   <= sumSat;
            trials_done <= trials_done + 8'd1;
         end
         if (timeoutHit) begin
            timeout_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_path_delay_meter.sv
// -----------------------------------------------------------------------------
// tb_path_delay_meter
// Directed bench for path_delay_meter with default parameters. path_result is
// driven by a small path model: zero-delay inverter, an inverter delayed by a
// programmable number of clk cycles, or stuck low.
// -----------------------------------------------------------------------------
module tb_path_delay_meter;

   localparam int CNT_W = 16;
   localparam int SUM_W = 24;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [7:0]       trials = 8'd0;
   logic             pathLaunch;
   logic             pathResult;
   logic             busy;
   logic             done;
   logic             timeoutErr;
   logic [CNT_W-1:0] delayLast;
   logic [SUM_W-1:0] delaySum;
   logic [7:0]       trialsDone;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   path_delay_meter dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .trials      (trials),
      .path_launch (pathLaunch),
      .path_result (pathResult),
      .busy        (busy),
      .done        (done),
      .timeout_err (timeoutErr),
      .delay_last  (delayLast),
      .delay_sum   (delaySum),
      .trials_done (trialsDone)
   );

   // Path model: registered history of path_launch, tapped at modelDelay.
   logic [1023:0] hist = '0;
   int            modelDelay = 0;
   logic          stuckLow = 1'b0;

   always @(posedge clk) hist <= {hist[1022:0], pathLaunch};

   always_comb begin
      if (stuckLow)
         pathResult = 1'b0;
      else if (modelDelay == 0)
         pathResult = ~pathLaunch;
      else
         pathResult = ~hist[modelDelay-1];
   end

   // Monitors: cycle counter, done pulses and path_launch edge times.
   int   cyc = 0;
   int   doneTotal = 0;
   int   launchTotal = 0;
   int   launchAt [256];
   logic prevLaunch = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done === 1'b1) doneTotal <= doneTotal + 1;
      if (pathLaunch !== prevLaunch && launchTotal < 256) begin
         launchAt[launchTotal] <= cyc;
         launchTotal <= launchTotal + 1;
      end
      prevLaunch <= pathLaunch;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called on a negedge; returns on the negedge after the accepting edge.
   task automatic runStart(input logic [7:0] n);
      start  = 1'b1;
      trials = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int budget, output int doneCyc);
      int i = 0;
      while (done !== 1'b1 && i < budget) begin
         @(negedge clk);
         i++;
      end
      check({tag, "_done_seen"}, 32'(done === 1'b1), 32'd1);
      doneCyc = cyc;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish by t=200000");
      $fatal(1);
   end

   initial begin
      int dc;
      int lb;
      int db;
      int i;

      // Reset state, and reset wins over start.
      repeat (3) @(negedge clk);
      check("rst_launch", 32'(pathLaunch), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_tmo", 32'(timeoutErr), 32'd0);
      check("rst_last", 32'(delayLast), 32'd0);
      check("rst_sum", 32'(delaySum), 32'd0);
      check("rst_cnt", 32'(trialsDone), 32'd0);
      start  = 1'b1;
      trials = 8'd3;
      @(negedge clk);
      check("rst_over_start", 32'(busy), 32'd0);
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);
      check("idle_after_rst", 32'(busy), 32'd0);

      // Zero-delay loopback, 4 trials: each trial reads SYNC_STAGES = 2.
      modelDelay = 0;
      db = doneTotal;
      runStart(8'd4);
      check("loop_busy", 32'(busy), 32'd1);
      waitDone("loop", 200, dc);
      check("loop_last", 32'(delayLast), 32'd2);
      check("loop_sum", 32'(delaySum), 32'd8);
      check("loop_cnt", 32'(trialsDone), 32'd4);
      check("loop_tmo", 32'(timeoutErr), 32'd0);
      tick(3);
      check("loop_pulses", 32'(doneTotal - db), 32'd1);
      check("loop_idle", 32'(busy), 32'd0);
      check("loop_level", 32'(pathLaunch), 32'd0);

      // Registered delay D=5, 3 trials: 5 + 2 = 7 each; edges 7 + 8 + 1 apart.
      modelDelay = 5;
      lb = launchTotal;
      runStart(8'd3);
      waitDone("d5", 300, dc);
      check("d5_last", 32'(delayLast), 32'd7);
      check("d5_sum", 32'(delaySum), 32'd21);
      check("d5_cnt", 32'(trialsDone), 32'd3);
      check("d5_tmo", 32'(timeoutErr), 32'd0);
      tick(2);
      check("d5_edges", 32'(launchTotal - lb), 32'd3);
      check("d5_gap1", 32'(launchAt[lb+1] - launchAt[lb]), 32'd16);
      check("d5_gap2", 32'(launchAt[lb+2] - launchAt[lb+1]), 32'd16);
      check("d5_level", 32'(pathLaunch), 32'd1);

      // Stuck low: launch falls, expects 1, never sees it -> timeout.
      stuckLow = 1'b1;
      lb = launchTotal;
      runStart(8'd2);
      waitDone("stuck", 1200, dc);
      check("stuck_tmo", 32'(timeoutErr), 32'd1);
      check("stuck_cnt", 32'(trialsDone), 32'd0);
      check("stuck_sum", 32'(delaySum), 32'd0);
      check("stuck_last_held", 32'(delayLast), 32'd7);
      tick(2);
      check("stuck_edges", 32'(launchTotal - lb), 32'd1);
      check("stuck_latency", 32'(dc - launchAt[lb]), 32'd1001);
      stuckLow = 1'b0;

      // trials = 0: done the next cycle, no launch, everything cleared.
      lb = launchTotal;
      runStart(8'd0);
      check("zero_done", 32'(done), 32'd1);
      check("zero_level", 32'(pathLaunch), 32'd0);
      check("zero_tmo", 32'(timeoutErr), 32'd0);
      check("zero_last", 32'(delayLast), 32'd0);
      check("zero_sum", 32'(delaySum), 32'd0);
      check("zero_cnt", 32'(trialsDone), 32'd0);
      tick(1);
      check("zero_pulse_end", 32'(done), 32'd0);
      check("zero_idle", 32'(busy), 32'd0);
      check("zero_edges", 32'(launchTotal - lb), 32'd0);

      // D=998: match lands on WAIT cycle 1000 together with TIMEOUT.
      modelDelay = 998;
      tick(1100);
      runStart(8'd1);
      waitDone("edge", 1200, dc);
      check("edge_last", 32'(delayLast), 32'd1000);
      check("edge_sum", 32'(delaySum), 32'd1000);
      check("edge_cnt", 32'(trialsDone), 32'd1);
      check("edge_tmo", 32'(timeoutErr), 32'd0);
      tick(2);

      // Reset mid-WAIT of trial 2, then a fresh run with an ignored start.
      modelDelay = 5;
      lb = launchTotal;
      runStart(8'd3);
      i = 0;
      while (launchTotal - lb < 2 && i < 100) begin
         @(negedge clk);
         i++;
      end
      check("mid_trial2_reached", 32'(launchTotal - lb >= 2), 32'd1);
      tick(3);
      check("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("mid_launch", 32'(pathLaunch), 32'd0);
      check("mid_busy0", 32'(busy), 32'd0);
      check("mid_done", 32'(done), 32'd0);
      check("mid_tmo", 32'(timeoutErr), 32'd0);
      check("mid_last", 32'(delayLast), 32'd0);
      check("mid_sum", 32'(delaySum), 32'd0);
      check("mid_cnt", 32'(trialsDone), 32'd0);

      modelDelay = 0;
      tick(2);
      db = doneTotal;
      runStart(8'd2);
      tick(3);
      check("fresh_busy", 32'(busy), 32'd1);
      start  = 1'b1;
      trials = 8'd5;
      tick(1);
      start = 1'b0;
      waitDone("fresh", 100, dc);
      check("fresh_last", 32'(delayLast), 32'd2);
      check("fresh_sum", 32'(delaySum), 32'd4);
      check("fresh_cnt", 32'(trialsDone), 32'd2);
      check("fresh_tmo", 32'(timeoutErr), 32'd0);
      tick(20);
      check("no_queue_idle", 32'(busy), 32'd0);
      check("no_queue_pulses", 32'(doneTotal - db), 32'd1);
      check("no_queue_cnt", 32'(trialsDone), 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
